// File: rtl/piezo_pkg.sv
// Shared note codes, tone frequencies, FSM state codes and the half-period helper
// for the piezo tone generator.
package piezo_pkg;

  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_C4   = 4'd1;
  localparam logic [3:0] NOTE_D4   = 4'd2;
  localparam logic [3:0] NOTE_E4   = 4'd3;
  localparam logic [3:0] NOTE_F4   = 4'd4;
  localparam logic [3:0] NOTE_G4   = 4'd5;
  localparam logic [3:0] NOTE_A4   = 4'd6;
  localparam logic [3:0] NOTE_B4   = 4'd7;
  localparam logic [3:0] NOTE_C5   = 4'd8;

  // Entry i is the frequency of note code i+1, in Hz.
  localparam int unsigned FREQ_HZ [0:7] = '{32'd262, 32'd294, 32'd330, 32'd349,
                                            32'd392, 32'd440, 32'd494, 32'd523};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_TONE = 2'd1;
  localparam logic [1:0] ST_BUZZ = 2'd2;

  function automatic int unsigned half_period(input int unsigned clk_hz, input int unsigned f);
    if (f == 32'd0) begin
      return 32'd0;
    end else begin
      return clk_hz / (32'd2 * f);
    end
  endfunction

endpackage

// File: rtl/piezo_tone_gen_note_half_rom.sv
// Combinational note-code to half-period lookup; rest and invalid codes give 0.
module note_half_rom #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int          CNT_W  = 18
) (
  input  logic [3:0]       code,
  output logic [CNT_W-1:0] half
);
  import piezo_pkg::*;

  localparam logic [CNT_W-1:0] H_C4 = CNT_W'(half_period(CLK_HZ, FREQ_HZ[0]));
  localparam logic [CNT_W-1:0] H_D4 = CNT_W'(half_period(CLK_HZ, FREQ_HZ[1]));
  localparam logic [CNT_W-1:0] H_E4 = CNT_W'(half_period(CLK_HZ, FREQ_HZ[2]));
  localparam logic [CNT_W-1:0] H_F4 = CNT_W'(half_period(CLK_HZ, FREQ_HZ[3]));
  localparam logic [CNT_W-1:0] H_G4 = CNT_W'(half_period(CLK_HZ, FREQ_HZ[4]));
  localparam logic [CNT_W-1:0] H_A4 = CNT_W'(half_period(CLK_HZ, FREQ_HZ[5]));
  localparam logic [CNT_W-1:0] H_B4 = CNT_W'(half_period(CLK_HZ, FREQ_HZ[6]));
  localparam logic [CNT_W-1:0] H_C5 = CNT_W'(half_period(CLK_HZ, FREQ_HZ[7]));

  always_comb begin
    case (code)
      NOTE_C4: half = H_C4;
      NOTE_D4: half = H_D4;
      NOTE_E4: half = H_E4;
      NOTE_F4: half = H_F4;
      NOTE_G4: half = H_G4;
      NOTE_A4: half = H_A4;
      NOTE_B4: half = H_B4;
      NOTE_C5: half = H_C5;
      default: half = '0;
    endcase
  end

endmodule

// File: rtl/piezo_tone_gen.sv
// Piezo square-wave generator: 50% duty note tones with an optional miss buzz,
// enabled by defining PIEZO_MISS_BUZZ_EN.
module piezo_tone_gen #(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int          CNT_W       = 18,
  parameter int unsigned MISS_CYCLES = 25_000_000,
  parameter int unsigned BUZZ_HZ     = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] note,
  input  logic       miss,
  output logic       piezo,
  output logic       busy,
  output logic [3:0] cur_note
);
  import piezo_pkg::*;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             piezo_q, piezo_d;
  logic             busy_q, busy_d;
  logic [3:0]       cur_note_q, cur_note_d;
  logic [3:0]       note_s;
  logic [CNT_W-1:0] half_s;
  logic             go_buzz_s;

  note_half_rom #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W)) u_rom (
    .code (cur_note_q),
    .half (half_s)
  );

`ifdef PIEZO_MISS_BUZZ_EN
  // The duration counter is sized from MISS_CYCLES, which can exceed CNT_W bits.
  localparam int               DUR_W     = (MISS_CYCLES > 32'd1) ? $clog2(MISS_CYCLES) : 1;
  localparam logic [DUR_W-1:0] DUR_LOAD  = DUR_W'(MISS_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] BUZZ_HALF = CNT_W'(half_period(CLK_HZ, BUZZ_HZ));

  logic             miss_q, miss_d;
  logic [DUR_W-1:0] dur_q, dur_d;

  assign go_buzz_s = miss & ~miss_q;
`else
  // The miss input and buzz parameters have no function in this build.
  logic miss_unused_s;
  assign miss_unused_s = miss & (MISS_CYCLES != 32'd0) & (BUZZ_HZ != 32'd0);
  assign go_buzz_s     = 1'b0;
`endif

  always_comb begin
    if ((note >= NOTE_C4) && (note <= NOTE_C5)) begin
      note_s = note;
    end else begin
      note_s = NOTE_REST;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    piezo_d = piezo_q;
    if (note_s != cur_note_q) begin
      cur_note_d = note_s;
    end else begin
      cur_note_d = cur_note_q;
    end
`ifdef PIEZO_MISS_BUZZ_EN
    miss_d = miss;
    dur_d  = go_buzz_s ? DUR_LOAD : dur_q;
`endif
    case (state_q)
      ST_IDLE, ST_TONE: begin
        if (go_buzz_s) begin
          state_d = ST_BUZZ;
          cnt_d   = '0;
          piezo_d = 1'b0;
        end else if ((cur_note_d != cur_note_q) || (state_q == ST_IDLE)) begin
          state_d = (cur_note_d != NOTE_REST) ? ST_TONE : ST_IDLE;
          cnt_d   = '0;
          piezo_d = 1'b0;
        end else if (cnt_q == (half_s - CNT_W'(1))) begin
          cnt_d   = '0;
          piezo_d = ~piezo_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef PIEZO_MISS_BUZZ_EN
      ST_BUZZ: begin
        // A note change only updates cur_note here; it is heard once the buzz ends.
        if ((dur_q == '0) && !go_buzz_s) begin
          state_d = (cur_note_d != NOTE_REST) ? ST_TONE : ST_IDLE;
          cnt_d   = '0;
          piezo_d = 1'b0;
        end else begin
          dur_d = go_buzz_s ? DUR_LOAD : (dur_q - DUR_W'(1));
          if (cnt_q == (BUZZ_HALF - CNT_W'(1))) begin
            cnt_d   = '0;
            piezo_d = ~piezo_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        piezo_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      piezo_q    <= 1'b0;
      busy_q     <= 1'b0;
      cur_note_q <= NOTE_REST;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      piezo_q    <= piezo_d;
      busy_q     <= busy_d;
      cur_note_q <= cur_note_d;
    end
  end

`ifdef PIEZO_MISS_BUZZ_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      miss_q <= 1'b0;
      dur_q  <= '0;
    end else begin
      miss_q <= miss_d;
      dur_q  <= dur_d;
    end
  end
`endif

  assign piezo    = piezo_q;
  assign busy     = busy_q;
  assign cur_note = cur_note_q;

endmodule

// File: tb/tb_piezo_tone_gen.sv
// Randomised and directed bench for piezo_tone_gen against a time-based tone model.
`timescale 1ns/1ps
module tb_piezo_tone_gen;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int          MISS   = 10_000;
  localparam int          BUZZ_F = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] note = 4'd0;
  logic       miss = 1'b0;
  logic       piezo;
  logic       busy;
  logic [3:0] cur_note;

  piezo_tone_gen #(
    .CLK_HZ(CLK_HZ), .CNT_W(18), .MISS_CYCLES(MISS), .BUZZ_HZ(BUZZ_F)
  ) dut (
    .clk(clk), .reset(reset), .note(note), .miss(miss),
    .piezo(piezo), .busy(busy), .cur_note(cur_note)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Model: edge index, mode (0 idle, 1 tone, 2 buzz), latched note, segment origins.
  int t        = 0;
  int m_mode   = 0;
  int m_cur    = 0;
  int m_seg    = 0;
  int m_bstart = 0;
  int m_bend   = 0;
  bit m_mprev  = 1'b0;
  int freq_tbl [0:7] = '{262, 294, 330, 349, 392, 440, 494, 523};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", tag, t, got, exp);
    end
  endtask

  function automatic int sanitize(input int c);
    return (c >= 1 && c <= 8) ? c : 0;
  endfunction

  function automatic int half_of(input int c);
    return int'(CLK_HZ) / (2 * freq_tbl[c-1]);
  endfunction

  function automatic int exp_piezo();
    if (m_mode == 1) return ((t - m_seg) / half_of(m_cur)) % 2;
    else if (m_mode == 2) return ((t - m_bstart) / (int'(CLK_HZ) / (2 * BUZZ_F))) % 2;
    else return 0;
  endfunction

  task automatic model_update();
    int  s;
    int  prior;
    bit  chg;
    bit  medge;
    t++;
    if (reset) begin
      m_mode = 0; m_cur = 0; m_mprev = 1'b0; m_seg = t;
      return;
    end
    s     = sanitize(int'(note));
    medge = 1'b0;
`ifdef PIEZO_MISS_BUZZ_EN
    medge = miss && !m_mprev;
`endif
    m_mprev = miss;
    prior   = m_mode;
    chg     = (s != m_cur);
    m_cur   = s;
    if (prior != 2 && chg) begin
      m_mode = (s != 0) ? 1 : 0;
      m_seg  = t;
    end
    if (prior == 2 && !medge && t == m_bend) begin
      m_mode = (m_cur != 0) ? 1 : 0;
      m_seg  = t;
    end
    if (medge) begin
      if (prior != 2) begin
        m_mode   = 2;
        m_bstart = t;
      end
      m_bend = t + MISS;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_val("piezo", piezo, exp_piezo());
    check_val("busy", busy, (m_mode != 0));
    check_val("cur_note", cur_note, m_cur);
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  // Steps until the selected output (0 piezo, 1 busy) equals lvl; n = -1 if the bound expires.
  task automatic wait_for(input int sel, input logic lvl, input int bound, output int n);
    logic v;
    n = 0;
    forever begin
      step();
      n++;
      v = (sel == 0) ? piezo : busy;
      if (v === lvl) break;
      if (n >= bound) begin
        n = -1;
        break;
      end
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    run(3);
    check_val("rst_piezo", piezo, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_cur", cur_note, 0);

    reset = 1'b0;
    note  = 4'd6;
    step();
    wait_for(0, 1'b1, 3000, n); check_val("a4_rise", n, 1136);
    wait_for(0, 1'b0, 3000, n); check_val("a4_fall", n, 1136);
    check_val("a4_busy", busy, 1);
    check_val("a4_cur", cur_note, 6);

    wait_for(0, 1'b1, 3000, n);
    run(100);
    note = 4'd8;
    step();
    check_val("chg_piezo", piezo, 0);
    wait_for(0, 1'b1, 3000, n); check_val("c5_rise", n, 956);
    check_val("c5_cur", cur_note, 8);

    note = 4'd12;
    step();
    check_val("inv_cur", cur_note, 0);
    check_val("inv_busy", busy, 0);
    check_val("inv_piezo", piezo, 0);
    run(20);

    note = 4'd3;
    run(300);
`ifdef PIEZO_MISS_BUZZ_EN
    miss = 1'b1;
    step();
    wait_for(0, 1'b1, 6000, n); check_val("buzz_rise", n, 2500);
    wait_for(0, 1'b0, 6000, n); check_val("buzz_fall", n, 2500);
    wait_for(0, 1'b1, 6000, n); check_val("buzz_rise2", n, 2500);
    wait_for(0, 1'b0, 6000, n); check_val("buzz_end", n, 2500);
`endif
    wait_for(0, 1'b1, 4000, n);
    wait_for(0, 1'b0, 4000, n); check_val("e4_half", n, 1515);

`ifdef PIEZO_MISS_BUZZ_EN
    miss = 1'b0;
    step();
    miss = 1'b1;
    step();
    miss = 1'b0;
    run(3998);
    miss = 1'b1;
    note = 4'd0;
    step();
    check_val("rebuzz_busy", busy, 1);
    wait_for(1, 1'b0, 12000, n); check_val("rebuzz_len", n, MISS);

    note = 4'd5;
    miss = 1'b0;
    step();
    miss = 1'b1;
    step();
    run(3000);
`else
    miss = 1'b1;
    note = 4'd0;
    step();
    check_val("rest_busy", busy, 0);
    note = 4'd5;
    run(500);
`endif
    reset = 1'b1;
    miss  = 1'b0;
    step();
    check_val("mid_rst_piezo", piezo, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_cur", cur_note, 0);
    reset = 1'b0;
    note  = 4'd1;
    step();
    wait_for(0, 1'b1, 4000, n); check_val("c4_rise", n, 1908);

    for (int i = 0; i < 120; i++) begin
      note = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) miss = ~miss;
      reset = ($urandom_range(0, 39) == 0);
      step();
      reset = 1'b0;
      run(int'($urandom_range(1, 300)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
